// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multicycle fetch/decode/execute/memory/writeback control FSM
module cpu_ctrl_fsm #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        alu_zero,
    output logic        imem_req,
    output logic        ir_load,
    output logic        pc_load,
    output logic [2:0]  alu_op,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic        rf_we,
    output logic        rf_wd_sel,
    output logic        dmem_re,
    output logic        dmem_we,
    output logic        halted,
    output logic        bus_err,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        ERR    = 3'd7
    } state_t;

    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;

    localparam logic [1:0] A_RS   = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;
    localparam logic [1:0] B_RT   = 2'd0;
    localparam logic [1:0] B_IMM  = 2'd1;
    localparam logic [1:0] B_ONE  = 2'd2;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_next;
    logic [7:0] wait_cnt;
    logic       beq_ph;
    logic       zero_q;
    logic [3:0] opcode;
    logic       unused_instr;

    assign opcode       = instr[15:12];
    assign unused_instr = ^instr[11:0];
    assign state_dbg    = state;

    // BEQ spends two cycles in EXEC; beq_ph marks the second (PC+imm) cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            beq_ph   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= (state_next == state && (state == FETCH || state == MEM))
                        ? wait_cnt + 8'd1 : 8'd0;
            beq_ph   <= (state == EXEC) && (opcode == OP_BEQ) && !beq_ph;
            if (state == EXEC && opcode == OP_BEQ && !beq_ph)
                zero_q <= alu_zero;
        end
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        pc_load    = 1'b0;
        alu_op     = ALU_ADD;
        alu_a_sel  = A_RS;
        alu_b_sel  = B_RT;
        rf_we      = 1'b0;
        rf_wd_sel  = 1'b0;
        dmem_re    = 1'b0;
        dmem_we    = 1'b0;
        halted     = 1'b0;
        bus_err    = 1'b0;

        case (state)
            IDLE: begin
                if (run)
                    state_next = FETCH;
            end
            FETCH: begin
                imem_req  = 1'b1;
                alu_a_sel = A_PC;
                alu_b_sel = B_ONE;
                if (imem_ready) begin
                    ir_load    = 1'b1;
                    pc_load    = 1'b1;
                    state_next = DECODE;
                end else if (wait_cnt >= WAIT_LAST) begin
                    state_next = ERR;
                end
            end
            DECODE: begin
                if (opcode <= OP_JMP)
                    state_next = EXEC;
                else if (opcode == OP_HLT)
                    state_next = HALT;
                else
                    state_next = FETCH;
            end
            EXEC: begin
                state_next = FETCH;
                if (opcode < OP_ADDI) begin
                    alu_op     = opcode[2:0];
                    state_next = WB;
                end else if (opcode == OP_ADDI) begin
                    alu_b_sel  = B_IMM;
                    state_next = WB;
                end else if (opcode == OP_LD || opcode == OP_ST) begin
                    alu_b_sel  = B_IMM;
                    state_next = MEM;
                end else if (opcode == OP_BEQ) begin
                    if (!beq_ph) begin
                        alu_op     = ALU_SUB;
                        state_next = EXEC;
                    end else begin
                        alu_a_sel = A_PC;
                        alu_b_sel = B_IMM;
                        pc_load   = zero_q;
                    end
                end else if (opcode == OP_JMP) begin
                    alu_a_sel = A_ZERO;
                    alu_b_sel = B_IMM;
                    pc_load   = 1'b1;
                end
            end
            MEM: begin
                alu_b_sel = B_IMM;
                dmem_re   = (opcode == OP_LD);
                dmem_we   = (opcode == OP_ST);
                if (dmem_ready)
                    state_next = (opcode == OP_LD) ? WB : FETCH;
                else if (wait_cnt >= WAIT_LAST)
                    state_next = ERR;
            end
            WB: begin
                rf_we     = 1'b1;
                rf_wd_sel = (opcode == OP_LD);
                // keep the EXEC operand selects so the RF captures the ALU result
                if (opcode < OP_ADDI)
                    alu_op = opcode[2:0];
                else if (opcode == OP_ADDI)
                    alu_b_sel = B_IMM;
                state_next = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            ERR: begin
                bus_err = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - table-driven and directed checks for cpu_ctrl_fsm
module tb_cpu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        alu_zero = 1'b0;
    logic        imem_req, ir_load, pc_load, rf_we, rf_wd_sel;
    logic        dmem_re, dmem_we, halted, bus_err;
    logic [2:0]  alu_op, state_dbg;
    logic [1:0]  alu_a_sel, alu_b_sel;

    int n_cmp = 0;
    int n_err = 0;

    cpu_ctrl_fsm #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .run(run), .instr(instr),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .alu_zero(alu_zero),
        .imem_req(imem_req), .ir_load(ir_load), .pc_load(pc_load),
        .alu_op(alu_op), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .rf_we(rf_we), .rf_wd_sel(rf_wd_sel), .dmem_re(dmem_re), .dmem_we(dmem_we),
        .halted(halted), .bus_err(bus_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] I_ADD  = 16'h0123;
    localparam logic [15:0] I_OR   = 16'h3456;
    localparam logic [15:0] I_ADDI = 16'h4107;
    localparam logic [15:0] I_LD   = 16'h5105;
    localparam logic [15:0] I_ST   = 16'h6107;
    localparam logic [15:0] I_BEQ  = 16'h7203;
    localparam logic [15:0] I_JMP  = 16'h8010;
    localparam logic [15:0] I_ILL  = 16'h9000;
    localparam logic [15:0] I_HLT  = 16'hF000;

    typedef struct {
        logic        run;
        logic [15:0] instr;
        logic        iready;
        logic        dready;
        logic        zero;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic [15:0] i, input logic ir,
                               input logic dr, input logic z, input logic [2:0] st,
                               input logic req, input logic irl, input logic pcl,
                               input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                               input logic rfw, input logic wd, input logic re,
                               input logic we, input logic h, input logic e);
        vec_t t;
        t.run = r; t.instr = i; t.iready = ir; t.dready = dr; t.zero = z;
        t.exp = {st, req, irl, pcl, op, a, b, rfw, wd, re, we, h, e};
        return t;
    endfunction

    function automatic logic [18:0] actual();
        return {state_dbg, imem_req, ir_load, pc_load, alu_op, alu_a_sel, alu_b_sel,
                rf_we, rf_wd_sel, dmem_re, dmem_we, halted, bus_err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [15:0] i, input logic ir,
                         input logic dr, input logic z);
        @(negedge clk);
        run = r; instr = i; imem_ready = ir; dmem_ready = dr; alu_zero = z;
        #1;
    endtask

    initial begin
        // {run,instr,ir,dr,z} | state req irl pcl op a b rfwe wd re we halt err
        vecs.push_back(v(0, I_ADD, 0,0,0, 0, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        vecs.push_back(v(1, I_ADD, 0,0,0, 0, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_ADD, 1,0,0, 1, 1,1,1, 0,1,2, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_ADD, 0,0,0, 2, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_ADD, 0,0,0, 3, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_ADD, 0,0,0, 5, 0,0,0, 0,0,0, 1,0,0,0,0,0));
        vecs.push_back(v(0, I_LD,  1,0,0, 1, 1,1,1, 0,1,2, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_LD,  0,0,0, 2, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_LD,  0,0,0, 3, 0,0,0, 0,0,1, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_LD,  0,0,0, 4, 0,0,0, 0,0,1, 0,0,1,0,0,0));
        vecs.push_back(v(0, I_LD,  0,0,0, 4, 0,0,0, 0,0,1, 0,0,1,0,0,0));
        vecs.push_back(v(0, I_LD,  0,1,0, 4, 0,0,0, 0,0,1, 0,0,1,0,0,0));
        vecs.push_back(v(0, I_LD,  0,0,0, 5, 0,0,0, 0,0,0, 1,1,0,0,0,0));
        vecs.push_back(v(0, I_BEQ, 0,0,0, 1, 1,0,0, 0,1,2, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_BEQ, 1,0,0, 1, 1,1,1, 0,1,2, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_BEQ, 0,0,0, 2, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_BEQ, 0,0,1, 3, 0,0,0, 1,0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_BEQ, 0,0,0, 3, 0,0,1, 0,1,1, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_BEQ, 1,0,0, 1, 1,1,1, 0,1,2, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_BEQ, 0,0,0, 2, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_BEQ, 0,0,0, 3, 0,0,0, 1,0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_BEQ, 0,0,1, 3, 0,0,0, 0,1,1, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_JMP, 1,0,0, 1, 1,1,1, 0,1,2, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_JMP, 0,0,0, 2, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_JMP, 0,0,0, 3, 0,0,1, 0,2,1, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_ILL, 1,0,0, 1, 1,1,1, 0,1,2, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_ILL, 0,0,0, 2, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_OR,  1,0,0, 1, 1,1,1, 0,1,2, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_OR,  0,0,0, 2, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_OR,  0,0,0, 3, 0,0,0, 3,0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_OR,  0,0,0, 5, 0,0,0, 3,0,0, 1,0,0,0,0,0));
        vecs.push_back(v(0, I_ADDI,1,0,0, 1, 1,1,1, 0,1,2, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_ADDI,0,0,0, 2, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_ADDI,0,0,0, 3, 0,0,0, 0,0,1, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_ADDI,0,0,0, 5, 0,0,0, 0,0,1, 1,0,0,0,0,0));
        vecs.push_back(v(0, I_ST,  1,0,0, 1, 1,1,1, 0,1,2, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_ST,  0,0,0, 2, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_ST,  0,0,0, 3, 0,0,0, 0,0,1, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_ST,  0,1,0, 4, 0,0,0, 0,0,1, 0,0,0,1,0,0));
        vecs.push_back(v(0, I_HLT, 1,0,0, 1, 1,1,1, 0,1,2, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_HLT, 0,0,0, 2, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0, I_HLT, 0,0,0, 6, 0,0,0, 0,0,0, 0,0,0,0,1,0));
        vecs.push_back(v(1, I_HLT, 1,1,0, 6, 0,0,0, 0,0,0, 0,0,0,0,1,0));
        vecs.push_back(v(0, I_HLT, 0,0,0, 6, 0,0,0, 0,0,0, 0,0,0,0,1,0));

        // reset state
        #2;
        chk("reset_state", 32'(actual()), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].run, vecs[k].instr, vecs[k].iready, vecs[k].dready, vecs[k].zero);
            chk($sformatf("row%0d", k), 32'(actual()), 32'(vecs[k].exp));
        end

        // reset out of HALT
        reset = 1'b0;
        #1;
        chk("halt_reset_state", 32'(state_dbg), 32'd0);
        chk("halt_reset_halted", 32'(halted), 32'd0);

        // imem never ready: 16 wait cycles in FETCH, then sticky ERR
        @(negedge clk);
        reset = 1'b1;
        drive(1, I_ADD, 0, 0, 0);
        for (int c = 0; c < 16; c++) begin
            drive(0, I_ADD, 0, 0, 0);
            chk($sformatf("timeout_wait%0d", c), 32'({state_dbg, imem_req}), 32'({3'd1, 1'b1}));
        end
        drive(0, I_ADD, 0, 0, 0);
        chk("timeout_err", 32'(actual()), 32'({3'd7, 15'd0, 1'b1}));
        drive(1, I_ADD, 1, 1, 0);
        drive(0, I_ADD, 1, 1, 0);
        chk("err_sticky", 32'(actual()), 32'({3'd7, 15'd0, 1'b1}));

        // asynchronous reset in the middle of a store
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        drive(1, I_ST, 0, 0, 0);
        drive(0, I_ST, 1, 0, 0);
        drive(0, I_ST, 0, 0, 0);
        drive(0, I_ST, 0, 0, 0);
        drive(0, I_ST, 0, 0, 0);
        chk("mem_st_we", 32'({state_dbg, dmem_we}), 32'({3'd4, 1'b1}));
        reset = 1'b0;
        #1;
        chk("async_reset_we", 32'(dmem_we), 32'd0);
        chk("async_reset_state", 32'(state_dbg), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
